ob_drain_streamer: RTL and testbench
====================================

// Module: ob_drain_streamer
// PURPOSE
// Drains result rows from the TPU output buffer read port (axim_rd_*) and streams them out as
// valid/ready beats toward the AXI master write path. Issues buffer reads and absorbs the 1-cycle
// read latency. Double-buffers rows and serializes each W-lane row into W/BEAT_LANES beats.
// Sits between tpu_core and the AXI write master; started by the control unit after writeback.
// PARAMETERS
// SYSTOLIC_ARRAY_WIDTH  16  lanes per row (W)
// DATA_WIDTH_ACCUM      32  bits per lane
// ADDR_WIDTH            10  output buffer address width
// BEAT_LANES            4   lanes per stream beat; must divide W; BEATS = W/BEAT_LANES
// PORTS
// clk           in   1                 clock
// rst           in   1                 reset: synchronous, active-high
// start         in   1                 launch drain; sampled only in IDLE
// base_addr     in   ADDR_WIDTH        first row address
// num_rows      in   ADDR_WIDTH+1      rows to drain (0..2^ADDR_WIDTH)
// busy          out  1                 high from the accepted start until done
// done          out  1                 1-cycle pulse after the final beat handshake
// ob_rd_addr    out  ADDR_WIDTH        to tpu_core axim_rd_addr_in
// ob_rd_en      out  1                 to tpu_core axim_rd_en_in
// ob_rd_data    in   32 x [W]          from tpu_core axim_rd_data_out; valid the cycle after ob_rd_en
// m_tdata       out  BEAT_LANES*32     beat payload
// m_tvalid      out  1                 beat valid
// m_tready      in   1                 sink ready
// m_tlast       out  1                 final beat of final row
// BEHAVIOUR
// - Reset: busy, done, ob_rd_en, m_tvalid, m_tlast = 0; ob_rd_addr, m_tdata = 0; FSM = IDLE.
// - Reset mid-drain aborts the drain. The in-flight read and both row slots are discarded. done does not fire.
// - FSM: IDLE -(start, num_rows>0)-> RUN -(last beat handshake)-> DONE -> IDLE (1 cycle, done=1).
//   - IDLE -(start, num_rows==0)-> DONE. No reads are issued and no beats are sent.
// - start in RUN or DONE is ignored.
// - Read issue: in RUN, ob_rd_en=1 when rows_issued<num_rows and a row slot is free.
//   - "Free" counts the slot targeted by the read in flight as occupied.
//   - Max one read per cycle. ob_rd_addr = base_addr + rows_issued, modulo 2^ADDR_WIDTH (wraps).
// - Capture: the cycle after ob_rd_en, ob_rd_data is written into the next slot of a 2-entry ping-pong row store.
// - Latency: start sampled at edge N -> ob_rd_en high in cycle N+1 -> first m_tvalid in cycle N+3.
// - Serialize: beat b of a row carries lanes [b*BEAT_LANES +: BEAT_LANES]. The lowest lane goes in m_tdata LSBs.
// - Beats leave in order b=0..BEATS-1; rows leave in address order.
// - Handshake: a beat transfers when m_tvalid && m_tready.
//   - m_tvalid never drops without a transfer.
//   - m_tdata and m_tlast are held stable while m_tvalid && !m_tready.
// - A slot frees on the handshake of its last beat. The next row's beat 0 may follow in the next cycle.
// - Sustained: 1 beat/cycle with m_tready=1 and BEATS>=2. No bubbles between rows.
// - m_tlast=1 only on beat BEATS-1 of row num_rows-1.
// - done pulses the cycle after that handshake; busy drops with done.
// - Simultaneous slot free (handshake) and capture in the same cycle must not lose or duplicate a row.
// CONFIGURATION
// - OB_DRAIN_PERF_EN defined:
//   - adds output stall_cycles [31:0]: counts cycles with m_tvalid && !m_tready;
//   - cleared on an accepted start and on rst; saturates at 2^32-1; holds after done.
// - OB_DRAIN_PERF_EN undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
// - tpu_pkg: the lane count and lane width constants, the BEATS localparam, and the drain_state_e enum (IDLE/RUN/DONE).
// - Sub-module ob_row_pingpong holds the 2-entry row store with wr/rd pointers, full/empty, and a beat index mux.
// - The top level holds the FSM, the address counter, the issue logic and the stream outputs.
// TESTING
// - Basic: base=0x010, num_rows=2, m_tready=1 (row r lane l = r*100+l).
//   - Reads at 0x010 and 0x011. 8 beats; beat0 = {3,2,1,0}; m_tlast on beat 7 only.
//   - done 1 cycle after beat 7; first m_tvalid 3 cycles after start.
// - Backpressure: num_rows=3, m_tready toggles 1/0 each cycle.
//   - 12 beats in order, payload stable while stalled; never more than 2 rows are read ahead.
//   - With OB_DRAIN_PERF_EN, stall_cycles = number of cycles with tvalid && !tready.
// - Wrap: base=0x3FE, num_rows=4 -> reads 0x3FE, 0x3FF, 0x000, 0x001 in that order.
// - Zero/ignored: num_rows=0 -> done the next cycle with no ob_rd_en. start pulsed mid-RUN -> no effect on the beat count.
// - Reset mid-drain: assert rst after beat 5 of 8.
//   - All outputs 0 the next cycle and no done.
//   - A new start with num_rows=1 then drains cleanly with 4 beats.
// - Throughput: num_rows=16, m_tready=1 -> 64 consecutive tvalid cycles with no gap; done at cycle 64+3.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU datapath constants and output-buffer drain FSM states.
package tpu_pkg;

  localparam int TPU_LANES     = 16;
  localparam int TPU_ACC_W     = 32;
  localparam int OB_ADDR_W     = 10;
  localparam int OB_BEAT_LANES = 4;
  localparam int OB_BEATS      = TPU_LANES / OB_BEAT_LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } drain_state_e;

endpackage

// File: rtl/ob_row_pingpong.sv
// Two-entry row store; serializes the head row into BEAT-lane beats.
module ob_row_pingpong #(
  parameter int W  = 16,
  parameter int DW = 32,
  parameter int BL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W*DW-1:0]  wr_row,
  input  logic             rd_adv,
  output logic [BL*DW-1:0] beat_data,
  output logic             beat_last,
  output logic [1:0]       count,
  output logic             empty
);

  localparam int NB = W / BL;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  logic [W*DW-1:0]  row_q [2];
  logic [BL*DW-1:0] beats [NB];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [BW-1:0]    beat;
  logic             free;

  assign beat_last = beat == BW'(NB - 1);
  assign free      = rd_adv && beat_last;
  assign empty     = count == 2'd0;

  for (genvar b = 0; b < NB; b++) begin : g_beat
    assign beats[b] = row_q[rd_ptr][b*BL*DW +: BL*DW];
  end

  assign beat_data = beats[beat];

  // Writer never targets the read slot while it is still draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q[0] <= '0;
      row_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      beat     <= '0;
      count    <= 2'd0;
    end else begin
      if (wr_en) begin
        row_q[wr_ptr] <= wr_row;
        wr_ptr        <= ~wr_ptr;
      end
      if (rd_adv) begin
        beat <= beat_last ? '0 : beat + BW'(1);
        if (beat_last) rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, wr_en} - {1'b0, free};
    end
  end

endmodule

// File: rtl/ob_drain_streamer.sv
// Drains output-buffer rows into a valid/ready beat stream.
// OB_DRAIN_PERF_EN adds the stall_cycles counter port.
module ob_drain_streamer
  import tpu_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_WIDTH = TPU_LANES,
  parameter int DATA_WIDTH_ACCUM     = TPU_ACC_W,
  parameter int ADDR_WIDTH           = OB_ADDR_W,
  parameter int BEAT_LANES           = OB_BEAT_LANES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_rows,
  output logic busy,
  output logic done,
  output logic [ADDR_WIDTH-1:0] ob_rd_addr,
  output logic ob_rd_en,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM-1:0] ob_rd_data,
  output logic [BEAT_LANES*DATA_WIDTH_ACCUM-1:0] m_tdata,
  output logic m_tvalid,
  input  logic m_tready,
  output logic m_tlast
`ifdef OB_DRAIN_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] ROW_ONE = 1;

  drain_state_e  state;
  logic [AW-1:0] base_q;
  logic [AW:0]   num_q;
  logic [AW:0]   issued;
  logic [AW:0]   sent;
  logic          cap_en;
  logic          hs;
  logic          row_done;
  logic          last_row;
  logic          issue_ok;
  logic          pp_empty;
  logic          pp_last;
  logic [1:0]    pp_count;
  logic [2:0]    occ;

  ob_row_pingpong #(
    .W  (SYSTOLIC_ARRAY_WIDTH),
    .DW (DATA_WIDTH_ACCUM),
    .BL (BEAT_LANES)
  ) u_pp (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (cap_en),
    .wr_row    (ob_rd_data),
    .rd_adv    (hs),
    .beat_data (m_tdata),
    .beat_last (pp_last),
    .count     (pp_count),
    .empty     (pp_empty)
  );

  assign m_tvalid = !pp_empty;
  assign hs       = m_tvalid && m_tready;
  assign row_done = hs && pp_last;
  assign last_row = sent == num_q - ROW_ONE;
  assign m_tlast  = m_tvalid && pp_last && last_row;

  // Slots held after this edge: stored rows, capture pending, read in flight.
  assign occ = {1'b0, pp_count}
             + {2'b00, cap_en}
             + {2'b00, ob_rd_en}
             - {2'b00, row_done};

  assign issue_ok = (state == RUN)
                 && (issued < num_q)
                 && (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ob_rd_en   <= 1'b0;
      ob_rd_addr <= '0;
      cap_en     <= 1'b0;
      base_q     <= '0;
      num_q      <= '0;
      issued     <= '0;
      sent       <= '0;
    end else begin
      done     <= 1'b0;
      ob_rd_en <= 1'b0;
      cap_en   <= ob_rd_en;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            num_q  <= num_rows;
            issued <= '0;
            sent   <= '0;
            if (num_rows == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue_ok) begin
            ob_rd_en   <= 1'b1;
            ob_rd_addr <= base_q + issued[AW-1:0];
            issued     <= issued + ROW_ONE;
          end
          if (row_done) begin
            sent <= sent + ROW_ONE;
            if (last_row) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OB_DRAIN_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      stall_cycles <= '0;
    end else if (m_tvalid && !m_tready && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ob_drain_streamer.sv
// Directed bench for ob_drain_streamer with a 1-cycle buffer model.
module tb_ob_drain_streamer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [9:0]   base_addr = '0;
  logic [10:0]  num_rows = '0;
  logic         busy;
  logic         done;
  logic [9:0]   ob_rd_addr;
  logic         ob_rd_en;
  logic [511:0] ob_rd_data = '0;
  logic [127:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic         m_tlast;
`ifdef OB_DRAIN_PERF_EN
  logic [31:0]  stall_cycles;
`endif

  ob_drain_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .busy       (busy),
    .done       (done),
    .ob_rd_addr (ob_rd_addr),
    .ob_rd_en   (ob_rd_en),
    .ob_rd_data (ob_rd_data),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast)
`ifdef OB_DRAIN_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic         l;
    int           c;
  } beat_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;
  int mem_base = 0;

  beat_t        beats [$];
  int           rd_addr [$];
  int           rd_cyc [$];
  int           first_v = -1;
  int           done_n = 0;
  int           done_c = -1;
  int           stall_n = 0;
  int           stab_viol = 0;
  int           max_ahead = 0;
  bit           pstall = 0;
  logic [127:0] pdata = '0;
  logic         plast = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output buffer: row index relative to base, lane l = idx*100 + l.
  always @(posedge clk) begin
    if (ob_rd_en) begin
      for (int l = 0; l < 16; l++) begin
        ob_rd_data[l*32 +: 32] <=
          32'((((int'(ob_rd_addr) - mem_base) & 1023) * 100) + l);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      int ahead;
      if (ob_rd_en) begin
        rd_addr.push_back(int'(ob_rd_addr));
        rd_cyc.push_back(cyc);
      end
      ahead = rd_addr.size() - beats.size() / 4;
      if (ahead > max_ahead) max_ahead = ahead;
      if (pstall && (!m_tvalid || m_tdata !== pdata || m_tlast !== plast))
        stab_viol++;
      pstall = m_tvalid && !m_tready;
      pdata  = m_tdata;
      plast  = m_tlast;
      if (m_tvalid && !m_tready) stall_n++;
      if (m_tvalid && first_v < 0) first_v = cyc;
      if (m_tvalid && m_tready) beats.push_back('{m_tdata, m_tlast, cyc});
      if (done) begin
        done_n++;
        done_c = cyc;
      end
    end
  end

  function automatic logic [127:0] exp_beat(int row, int b);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = 32'(row * 100 + b * 4 + k);
    return v;
  endfunction

  function automatic int bad_beats();
    int n = 0;
    for (int i = 0; i < beats.size(); i++)
      if (beats[i].d !== exp_beat(i / 4, i % 4)) n++;
    return n;
  endfunction

  function automatic int tlast_n();
    int n = 0;
    for (int i = 0; i < beats.size(); i++) if (beats[i].l) n++;
    return n;
  endfunction

  task automatic clear_mon();
    beats.delete();
    rd_addr.delete();
    rd_cyc.delete();
    first_v = -1;
    done_n = 0;
    done_c = -1;
    stall_n = 0;
    stab_viol = 0;
    max_ahead = 0;
    pstall = 0;
  endtask

  task automatic start_drain(input int base, input int n);
    base_addr = 10'(base);
    num_rows = 11'(n);
    mem_base = base;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic run_done(input int budget, input bit tog,
                          input int pulse_at, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      start = (i == pulse_at);
      if (start) num_rows = 11'd5;
      @(posedge clk);
      #1;
      if (tog) m_tready = !m_tready;
      if (done_n > 0) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, ob_rd_en, m_tvalid, m_tlast} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {busy, done, ob_rd_en, m_tvalid, m_tlast});
    end
    checks++;
    if (ob_rd_addr !== 10'h0) begin
      errors++;
      $display("FAIL reset_addr got=%h exp=000", ob_rd_addr);
    end
    checks++;
    if (m_tdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_tdata got=%h exp=0", m_tdata);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit ok;
    logic [127:0] b0 = {32'd3, 32'd2, 32'd1, 32'd0};
    int last_c;
    clear_mon();
    m_tready = 1'b1;
    start_drain(10'h010, 2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got=%b exp=1", busy);
    end
    run_done(100, 0, -1, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || done_n != 1) begin
      errors++;
      $display("FAIL basic_done got=%0d exp=1", done_n);
    end
    checks++;
    if (rd_addr.size() != 2 || rd_addr[0] != 'h10 || rd_addr[1] != 'h11) begin
      errors++;
      $display("FAIL basic_reads got=%p exp='{16,17}", rd_addr);
    end
    checks++;
    if (rd_cyc.size() < 1 || rd_cyc[0] - s_cyc != 1) begin
      errors++;
      $display("FAIL basic_rd_lat got=%p exp=start+1 (%0d)", rd_cyc, s_cyc);
    end
    checks++;
    if (beats.size() != 8) begin
      errors++;
      $display("FAIL basic_beats got=%0d exp=8", beats.size());
    end
    checks++;
    if (beats.size() < 1 || beats[0].d !== b0) begin
      errors++;
      $display("FAIL basic_beat0 got=%h exp=%h",
               beats.size() > 0 ? beats[0].d : 128'h0, b0);
    end
    checks++;
    if (bad_beats() != 0) begin
      errors++;
      $display("FAIL basic_data got=%0d bad exp=0", bad_beats());
    end
    checks++;
    if (tlast_n() != 1 || beats.size() < 1 || !beats[$].l) begin
      errors++;
      $display("FAIL basic_tlast got=%0d exp=1 on beat 7", tlast_n());
    end
    checks++;
    if (first_v - s_cyc != 3) begin
      errors++;
      $display("FAIL basic_tvalid_lat got=%0d exp=3", first_v - s_cyc);
    end
    last_c = beats.size() > 0 ? beats[$].c : -100;
    checks++;
    if (done_c - last_c != 1) begin
      errors++;
      $display("FAIL basic_done_lat got=%0d exp=1", done_c - last_c);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_end got=%b exp=0", busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_mon();
    m_tready = 1'b1;
    start_drain(10'h040, 3);
    run_done(200, 1, -1, ok);
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (!ok || beats.size() != 12 || bad_beats() != 0) begin
      errors++;
      $display("FAIL bp_beats got=%0d bad=%0d exp=12 bad=0",
               beats.size(), bad_beats());
    end
    checks++;
    if (stab_viol != 0) begin
      errors++;
      $display("FAIL bp_stable got=%0d exp=0", stab_viol);
    end
    checks++;
    if (max_ahead > 2 || rd_addr.size() != 3) begin
      errors++;
      $display("FAIL bp_ahead got=%0d reads=%0d exp<=2 reads=3",
               max_ahead, rd_addr.size());
    end
    checks++;
    if (tlast_n() != 1 || beats.size() < 1 || !beats[$].l) begin
      errors++;
      $display("FAIL bp_tlast got=%0d exp=1", tlast_n());
    end
    checks++;
    if (stall_n == 0) begin
      errors++;
      $display("FAIL bp_stalled got=0 exp>0");
    end
`ifdef OB_DRAIN_PERF_EN
    checks++;
    if (stall_cycles !== 32'(stall_n)) begin
      errors++;
      $display("FAIL bp_perf got=%0d exp=%0d", stall_cycles, stall_n);
    end
`endif
  endtask

  task automatic test_wrap();
    bit ok;
    clear_mon();
    start_drain(10'h3FE, 4);
    run_done(200, 0, -1, ok);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd_addr.size() != 4 || rd_addr[0] != 'h3FE || rd_addr[1] != 'h3FF
        || rd_addr[2] != 0 || rd_addr[3] != 1) begin
      errors++;
      $display("FAIL wrap_reads got=%p exp='{1022,1023,0,1}", rd_addr);
    end
    checks++;
    if (!ok || beats.size() != 16 || bad_beats() != 0) begin
      errors++;
      $display("FAIL wrap_beats got=%0d bad=%0d exp=16 bad=0",
               beats.size(), bad_beats());
    end
`ifdef OB_DRAIN_PERF_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL wrap_perf got=%0d exp=0", stall_cycles);
    end
`endif
  endtask

  task automatic test_zero();
    bit ok;
    clear_mon();
    start_drain(10'h055, 0);
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_flags got=busy%b done%b exp=busy0 done1", busy, done);
    end
    run_done(20, 0, -1, ok);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || done_n != 1 || done_c != s_cyc) begin
      errors++;
      $display("FAIL zero_done got=%0d@%0d exp=1@%0d", done_n, done_c, s_cyc);
    end
    checks++;
    if (rd_addr.size() != 0 || beats.size() != 0) begin
      errors++;
      $display("FAIL zero_traffic got=%0d/%0d exp=0/0",
               rd_addr.size(), beats.size());
    end
  endtask

  task automatic test_ignored_start();
    bit ok;
    clear_mon();
    start_drain(10'h100, 2);
    run_done(100, 0, 3, ok);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (!ok || beats.size() != 8 || bad_beats() != 0) begin
      errors++;
      $display("FAIL ign_beats got=%0d bad=%0d exp=8 bad=0",
               beats.size(), bad_beats());
    end
    checks++;
    if (rd_addr.size() != 2 || done_n != 1) begin
      errors++;
      $display("FAIL ign_count got=%0d/%0d exp=2/1", rd_addr.size(), done_n);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit = 0;
    clear_mon();
    m_tready = 1'b1;
    start_drain(10'h200, 2);
    for (int i = 0; i < 50; i++) begin
      if (beats.size() >= 6) begin
        hit = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rstmid_reach got=%0d beats exp=6", beats.size());
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, ob_rd_en, m_tvalid, m_tlast} !== 5'b0
        || m_tdata !== 128'h0 || ob_rd_addr !== 10'h0) begin
      errors++;
      $display("FAIL rstmid_outs got=%b %h %h exp=0",
               {busy, done, ob_rd_en, m_tvalid, m_tlast}, m_tdata, ob_rd_addr);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_n != 0) begin
      errors++;
      $display("FAIL rstmid_nodone got=%0d exp=0", done_n);
    end
    clear_mon();
    start_drain(10'h020, 1);
    run_done(60, 0, -1, ok);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (!ok || beats.size() != 4 || bad_beats() != 0 || tlast_n() != 1) begin
      errors++;
      $display("FAIL rstmid_redo got=%0d bad=%0d last=%0d exp=4 0 1",
               beats.size(), bad_beats(), tlast_n());
    end
  endtask

  task automatic test_throughput();
    bit ok;
    int gaps = 0;
    clear_mon();
    m_tready = 1'b1;
    start_drain(10'h080, 16);
    run_done(300, 0, -1, ok);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i < beats.size(); i++)
      if (beats[i].c != beats[i-1].c + 1) gaps++;
    checks++;
    if (!ok || beats.size() != 64 || bad_beats() != 0) begin
      errors++;
      $display("FAIL tput_beats got=%0d bad=%0d exp=64 bad=0",
               beats.size(), bad_beats());
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL tput_gaps got=%0d exp=0", gaps);
    end
    checks++;
    if (first_v - s_cyc != 3 || done_c - s_cyc != 67) begin
      errors++;
      $display("FAIL tput_timing got=%0d/%0d exp=3/67",
               first_v - s_cyc, done_c - s_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_ignored_start();
    test_reset_mid();
    test_throughput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
